fpu_issue_sequencer: RTL
========================

Name: fpu_issue_sequencer

Overview:
- Sits between the FPU operand front-end and the FPU functional units: classifier, add/sub, mul, div/sqrt, convert, and so on.
- Dispatches each accepted operation to the single unit selected by the op decoder.
- Records dispatch order in an order FIFO, and hands unit results to the writeback stage strictly in program order.
- Units that finish early are held off through their ready inputs.

Parameters:
- N_UNITS, 6, number of attached functional units; unit index width UW = max(1, $clog2(N_UNITS)).
- DEPTH, 4, order-FIFO entries, which is the maximum number of in-flight operations; power of two, ≥2.
- TAG_W, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; same effect as reset on this block's state.
- valid_in  in  1  upstream operation valid.
- ready_out  out  1  this block accepts the upstream operation.
- unit_sel  in  UW  decoded target unit index for the current operation.
- tag_in  in  TAG_W  destination tag of the current operation.
- unit_valid_out  out  N_UNITS  per-unit dispatch valid, one-hot or zero.
- unit_ready_in  in  N_UNITS  per-unit dispatch ready.
- unit_valid_in  in  N_UNITS  per-unit result valid.
- unit_ready_out  out  N_UNITS  per-unit result ready, one-hot or zero.
- unit_result_in  in  N_UNITS*32  flattened unit results; unit i occupies bits [32i+31:32i].
- unit_fflags_in  in  N_UNITS*5  flattened exception flags {NV,DZ,OF,UF,NX}; unit i occupies [5i+4:5i].
- valid_out  out  1  in-order result valid.
- ready_in  in  1  writeback accepts the result.
- result_out  out  32  in-order result.
- fflags_out  out  5  flags of the result.
- tag_out  out  TAG_W  tag of the result.
- busy  out  1  one or more operations are in flight (FIFO non-empty).

Behaviour:
- State: order FIFO of DEPTH entries, each {unit index, tag}; write pointer wp and read pointer rp (log2 DEPTH bits each, wrapping); count, 0..DEPTH.
- Reset or flush (synchronous, high): wp=rp=count=0. The flush is seen on the same edge. Entries are not cleared.
- Outputs in reset state:
  - busy=0 and valid_out=0.
  - unit_ready_out=0.
  - result_out, fflags_out and tag_out are all 0.
  - unit_valid_out follows the dispatch rule below; it is 0 while reset or flush is high.
- sel_ok = (unit_sel < N_UNITS). full = (count==DEPTH). empty = (count==0).
- Dispatch (combinational):
  - unit_valid_out[unit_sel] = valid_in && sel_ok && !full && !reset && !flush; all other bits are 0.
  - ready_out = sel_ok && !full && unit_ready_in[unit_sel] && !reset && !flush.
  - Push occurs when valid_in && ready_out: the FIFO entry at wp gets {unit_sel, tag_in}, then wp++.
  - An out-of-range unit_sel is never accepted: ready_out=0 and the upstream stalls. This is illegal stimulus, and the bench flags it.
- Completion (combinational from the head entry {h, htag} at rp):
  - valid_out = !empty && unit_valid_in[h].
  - result_out, fflags_out and tag_out take unit h's slices and htag while !empty; otherwise they are 0.
  - unit_ready_out[h] = !empty && ready_in; all other bits are 0. Non-head units that have finished hold their results.
  - Pop occurs when valid_out && ready_in: rp++.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, which is legal whenever !full.
- When full, push is blocked even if a pop happens in the same cycle. Push capacity frees on the following cycle.
- Pointer wrap: wp and rp wrap DEPTH-1 → 0 naturally. Full and empty are decided by count only.
- Latency:
  - Dispatch adds zero cycles; it is a combinational pass-through to the unit.
  - A result reaches writeback in the same cycle the head unit asserts valid, provided ready_in=1.
- busy = !empty. busy is registered-state derived, so it has no combinational path from the inputs.
- Multiple ops to the same unit are allowed. Each unit must return its results in its own acceptance order.

Test Plan:
- Reset then idle → busy=0, valid_out=0, unit_ready_out=0, ready_out=1 for valid_in=1, unit_sel=2, unit_ready_in=6'b000100. That op pushes; busy=1 next cycle.
- Out-of-order completion:
  - Dispatch tag 3 to unit 3 (div), then tag 4 to unit 0 (class).
  - Unit 0 result 0x40 is valid first → valid_out=0 and unit_ready_out[0]=0.
  - Unit 3 result 0x3F800000 arrives → output tag 3 / 0x3F800000, then tag 4 / 0x40 on the next cycle.
- Fill to DEPTH=4 with ready_in=0 → ready_out=0 on the 5th op even with a simultaneous unit_ready_in. Release ready_in for one pop → 5th op accepted the cycle after.
- Simultaneous push and pop at count=2 for 10 cycles → count stays 2; pointers wrap through 3→0 and tags still emerge in order.
- Flush with 3 ops in flight → next cycle busy=0 and valid_out=0. A valid unit result is then ignored (unit_ready_out=0).
- unit_sel=7 with N_UNITS=6 → ready_out=0, unit_valid_out=0, no push.

Source files
------------

// File: rtl/fpu_issue_sequencer.sv
// In-order issue/writeback sequencer for the FPU functional units.
// Dispatches each op to its decoded unit and retires unit results in program order.
module fpu_issue_sequencer #(
  parameter int N_UNITS = 6,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 5,
  localparam int UW     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [UW-1:0]          unit_sel,
  input  logic [TAG_W-1:0]       tag_in,
  output logic [N_UNITS-1:0]     unit_valid_out,
  input  logic [N_UNITS-1:0]     unit_ready_in,
  input  logic [N_UNITS-1:0]     unit_valid_in,
  output logic [N_UNITS-1:0]     unit_ready_out,
  input  logic [N_UNITS*32-1:0]  unit_result_in,
  input  logic [N_UNITS*5-1:0]   unit_fflags_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [31:0]            result_out,
  output logic [4:0]             fflags_out,
  output logic [TAG_W-1:0]       tag_out,
  output logic                   busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
  localparam logic [UW:0] NUNITS_C = (UW + 1)'(N_UNITS);

  logic [UW-1:0]    unit_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;

  logic             kill_s, full_s, empty_s, sel_ok_s, open_s, sel_rdy_s;
  logic             push_s, pop_s, head_valid_s;
  logic [UW-1:0]    h_s;
  logic [TAG_W-1:0] htag_s;
  logic [31:0]      head_res_s;
  logic [4:0]       head_flg_s;

  // Dispatch side: route the upstream op to the decoded unit.
  always_comb begin
    kill_s    = reset | flush;
    full_s    = (cnt_q == DEPTH_C);
    empty_s   = (cnt_q == {(PW + 1){1'b0}});
    sel_ok_s  = ({1'b0, unit_sel} < NUNITS_C);
    open_s    = sel_ok_s && !full_s && !kill_s;
    sel_rdy_s = 1'b0;
    unit_valid_out = {N_UNITS{1'b0}};
    for (int i = 0; i < N_UNITS; i++) begin
      sel_rdy_s         = sel_rdy_s | ((unit_sel == UW'(i)) & unit_ready_in[i]);
      unit_valid_out[i] = (unit_sel == UW'(i)) && valid_in && open_s;
    end
    ready_out = open_s && sel_rdy_s;
    push_s    = valid_in && ready_out;
  end

  // Completion side: only the unit owning the oldest in-flight op may retire.
  always_comb begin
    h_s          = unit_q[rp_q];
    htag_s       = tag_q[rp_q];
    head_valid_s = 1'b0;
    head_res_s   = 32'd0;
    head_flg_s   = 5'd0;
    unit_ready_out = {N_UNITS{1'b0}};
    for (int i = 0; i < N_UNITS; i++) begin
      logic hit;
      hit               = !empty_s && (h_s == UW'(i));
      head_valid_s      = head_valid_s | (hit & unit_valid_in[i]);
      head_res_s        = head_res_s | ({32{hit}} & unit_result_in[32*i +: 32]);
      head_flg_s        = head_flg_s | ({5{hit}} & unit_fflags_in[5*i +: 5]);
      unit_ready_out[i] = hit && ready_in;
    end
    valid_out  = head_valid_s;
    result_out = head_res_s;
    fflags_out = head_flg_s;
    if (empty_s) begin
      tag_out = {TAG_W{1'b0}};
    end else begin
      tag_out = htag_s;
    end
    pop_s = head_valid_s && ready_in;
    busy  = !empty_s;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_s) begin
      wp_d = wp_q + {{(PW - 1){1'b0}}, 1'b1};
    end else begin
      wp_d = wp_q;
    end
    if (pop_s) begin
      rp_d = rp_q + {{(PW - 1){1'b0}}, 1'b1};
    end else begin
      rp_d = rp_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + {{PW{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{PW{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/occupancy registers; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp_q  <= {PW{1'b0}};
      rp_q  <= {PW{1'b0}};
      cnt_q <= {(PW + 1){1'b0}};
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Order FIFO storage; entries are left stale on reset since count gates them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      unit_q[wp_q] <= unit_sel;
      tag_q[wp_q]  <= tag_in;
    end
  end

endmodule
